// File: rtl/core_pkg.sv
// Shared core definitions: the NOOP instruction word and the memory-port
// arbiter state encoding.
package core_pkg;
  localparam logic [31:0] NOOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the single memory port between fetch and load/store,
// one transaction outstanding, with a response timeout that returns a safe reply.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_EN,
  input  logic              i_I_REQ,
  input  logic [ADDR_W-1:0] i_I_ADDR,
  output logic              o_I_GNT,
  output logic              o_I_RVALID,
  output logic [31:0]       o_I_RDATA,
  input  logic              i_D_REQ,
  input  logic              i_D_WE,
  input  logic [3:0]        i_D_BE,
  input  logic [ADDR_W-1:0] i_D_ADDR,
  input  logic [31:0]       i_D_WDATA,
  output logic              o_D_GNT,
  output logic              o_D_RVALID,
  output logic [31:0]       o_D_RDATA,
  output logic              o_M_REQ,
  output logic              o_M_WE,
  output logic [3:0]        o_M_BE,
  output logic [ADDR_W-1:0] o_M_ADDR,
  output logic [31:0]       o_M_WDATA,
  input  logic              i_M_GNT,
  input  logic              i_M_RVALID,
  input  logic [31:0]       i_M_RDATA,
  output logic              o_BUS_ERR
);
  localparam int CW = $clog2(TIMEOUT + 1);
  // Counter is cleared in the grant cycle, so the TIMEOUT-th cycle after the
  // grant sees TIMEOUT-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t    state;
  logic          last_d;   // 1 = data requester was granted last
  logic          pend_vld; // a winner was presented but not yet accepted
  logic          pend_d;
  logic          wr_q;
  logic [CW-1:0] cnt;

  logic arb_d, sel_d, waiting, expired, resp;

  always_comb begin
    arb_d   = i_D_REQ && (!i_I_REQ || !last_d);
    sel_d   = pend_vld ? pend_d : arb_d;
    o_M_REQ = (state == IDLE) && i_EN && (i_I_REQ || i_D_REQ);
    o_M_WE    = sel_d ? i_D_WE    : 1'b0;
    o_M_BE    = sel_d ? i_D_BE    : 4'hF;
    o_M_ADDR  = sel_d ? i_D_ADDR  : i_I_ADDR;
    o_M_WDATA = sel_d ? i_D_WDATA : 32'd0;
    o_I_GNT = o_M_REQ && i_M_GNT && !sel_d;
    o_D_GNT = o_M_REQ && i_M_GNT && sel_d;

    waiting   = (state == WAIT_I) || (state == WAIT_D);
    expired   = waiting && (cnt == CNT_LAST);
    resp      = waiting && (i_M_RVALID || expired);
    o_BUS_ERR = expired && !i_M_RVALID;

    o_I_RVALID = resp && (state == WAIT_I);
    o_D_RVALID = resp && (state == WAIT_D);
    o_I_RDATA  = (state == WAIT_I && i_M_RVALID) ? i_M_RDATA : NOOP;
    o_D_RDATA  = (state == WAIT_D && i_M_RVALID && !wr_q) ? i_M_RDATA : 32'd0;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      pend_vld <= 1'b0;
      pend_d   <= 1'b0;
      wr_q     <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (o_M_REQ) begin
            if (i_M_GNT) begin
              state    <= sel_d ? WAIT_D : WAIT_I;
              last_d   <= sel_d;
              wr_q     <= sel_d && i_D_WE;
              pend_vld <= 1'b0;
              cnt      <= '0;
            end else begin
              pend_vld <= 1'b1;
              pend_d   <= sel_d;
            end
          end
        end
        WAIT_I, WAIT_D: begin
          if (resp) state <= IDLE;
          else      cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter (TIMEOUT=4): fetch, contention,
// stall hold, write, timeout, reset abort and enable gating.
module tb_mem_port_arbiter;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        i_req, d_req, d_we, m_gnt, m_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_be;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, bus_err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .i_CLK(clk), .i_RST(rst), .i_EN(en),
    .i_I_REQ(i_req), .i_I_ADDR(i_addr), .o_I_GNT(i_gnt),
    .o_I_RVALID(i_rvalid), .o_I_RDATA(i_rdata),
    .i_D_REQ(d_req), .i_D_WE(d_we), .i_D_BE(d_be), .i_D_ADDR(d_addr),
    .i_D_WDATA(d_wdata), .o_D_GNT(d_gnt), .o_D_RVALID(d_rvalid),
    .o_D_RDATA(d_rdata),
    .o_M_REQ(m_req), .o_M_WE(m_we), .o_M_BE(m_be), .o_M_ADDR(m_addr),
    .o_M_WDATA(m_wdata), .i_M_GNT(m_gnt), .i_M_RVALID(m_rvalid),
    .i_M_RDATA(m_rdata), .o_BUS_ERR(bus_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    i_req = 0; d_req = 0; d_we = 0; m_gnt = 0; m_rvalid = 0;
    d_be = 4'hF; m_rdata = 32'h0; d_wdata = 32'h0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  // respond to the outstanding transaction in the current cycle
  task automatic respond(input logic [31:0] data);
    m_gnt = 0; m_rvalid = 1; m_rdata = data;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    en = 1; i_addr = 32'h100; d_addr = 32'h300;
    clr_in();
    rst = 1;
    #2;
    chk("rst_m_req",   m_req, 0);
    chk("rst_i_gnt",   i_gnt, 0);
    chk("rst_d_gnt",   d_gnt, 0);
    chk("rst_i_rv",    i_rvalid, 0);
    chk("rst_d_rv",    d_rvalid, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_i_rdata", i_rdata, NOOP);
    chk("rst_d_rdata", d_rdata, 0);
    tick();
    rst = 0;

    // fetch only
    i_req = 1; m_gnt = 1; #1;
    chk("f_m_req",  m_req, 1);
    chk("f_m_addr", m_addr, 32'h100);
    chk("f_i_gnt",  i_gnt, 1);
    chk("f_d_gnt",  d_gnt, 0);
    tick();
    i_req = 0; respond(32'hDEADBEEF);
    chk("f_i_rv",    i_rvalid, 1);
    chk("f_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("f_d_rv",    d_rvalid, 0);
    chk("f_d_rdata", d_rdata, 0);
    chk("f_rsp_req", m_req, 0);
    tick();

    // contention from reset: I, D, I, D
    do_reset();
    i_addr = 32'h200; d_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      i_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 0; #1;
      chk($sformatf("c%0d_i_gnt", k), i_gnt, (k % 2) == 0);
      chk($sformatf("c%0d_d_gnt", k), d_gnt, (k % 2) == 1);
      chk($sformatf("c%0d_addr", k), m_addr, (k % 2) ? 32'h300 : 32'h200);
      tick();
      respond(32'hA0 + k);
      chk($sformatf("c%0d_gnt_in_rsp", k), i_gnt | d_gnt, 0);
      chk($sformatf("c%0d_rv", k), (k % 2) ? d_rvalid : i_rvalid, 1);
      chk($sformatf("c%0d_rdata", k), (k % 2) ? d_rdata : i_rdata, 32'hA0 + k);
      tick();
    end

    // stall: both request, no grant for 3 cycles (last = D, so fetch selected)
    m_rvalid = 0; m_gnt = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("s%0d_addr", k), m_addr, 32'h200);
      chk($sformatf("s%0d_gnt", k), i_gnt | d_gnt, 0);
      tick();
    end
    m_gnt = 1; #1;
    chk("s_i_gnt", i_gnt, 1);
    tick();
    respond(32'h1); tick();

    // latched selection: fetch alone first, then D joins (arbitration alone would pick D)
    m_rvalid = 0; d_req = 0; i_req = 1; m_gnt = 0;
    tick();
    d_req = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("l%0d_addr", k), m_addr, 32'h200);
      tick();
    end
    m_gnt = 1; #1;
    chk("l_i_gnt", i_gnt, 1);
    chk("l_d_gnt", d_gnt, 0);
    tick();
    i_req = 0; d_req = 0; respond(32'h2); tick();

    // write
    clr_in();
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h400; d_wdata = 32'h12345678; m_gnt = 1; #1;
    chk("w_m_we",    m_we, 1);
    chk("w_m_be",    m_be, 4'b0011);
    chk("w_m_wdata", m_wdata, 32'h12345678);
    chk("w_m_addr",  m_addr, 32'h400);
    chk("w_d_gnt",   d_gnt, 1);
    tick();
    d_req = 0; d_we = 0; respond(32'hFFFFFFFF);
    chk("w_d_rv",    d_rvalid, 1);
    chk("w_d_rdata", d_rdata, 0);
    tick();

    // fetch timeout: grant in cycle 0, expiry in cycle 4
    clr_in();
    i_req = 1; m_gnt = 1; #1;
    chk("t_i_gnt", i_gnt, 1);
    tick();
    i_req = 0; m_gnt = 0;
    for (int k = 1; k < 4; k++) begin
      #1;
      chk($sformatf("t%0d_err", k), bus_err, 0);
      chk($sformatf("t%0d_rv", k), i_rvalid, 0);
      tick();
    end
    #1;
    chk("t4_err",   bus_err, 1);
    chk("t4_rv",    i_rvalid, 1);
    chk("t4_rdata", i_rdata, NOOP);
    tick();
    tick();
    respond(32'hBAD0BAD0);
    chk("t6_i_rv", i_rvalid, 0);
    chk("t6_d_rv", d_rvalid, 0);
    chk("t6_err",  bus_err, 0);
    tick();

    // response arriving in the expiry cycle wins over the timeout
    clr_in();
    d_req = 1; m_gnt = 1; #1;
    chk("tt_d_gnt", d_gnt, 1);
    tick();
    d_req = 0; m_gnt = 0;
    tick(); tick(); tick();
    respond(32'hCAFE);
    chk("tt_d_rv",    d_rvalid, 1);
    chk("tt_d_rdata", d_rdata, 32'hCAFE);
    chk("tt_err",     bus_err, 0);
    tick();

    // reset while in WAIT_D
    clr_in();
    d_req = 1; m_gnt = 1; #1;
    chk("r_d_gnt", d_gnt, 1);
    tick();
    d_req = 0; m_gnt = 0;
    rst = 1; #1;
    m_rvalid = 1; m_rdata = 32'h55; #1;
    chk("r_d_rv",    d_rvalid, 0);
    chk("r_err",     bus_err, 0);
    chk("r_d_rdata", d_rdata, 0);
    tick();
    rst = 0; m_rvalid = 0; #1;
    chk("r_m_req",   m_req, 0);
    chk("r_i_rdata", i_rdata, NOOP);
    // back in IDLE with last-granted = D: the fetch wins a tie
    i_req = 1; d_req = 1; m_gnt = 1; i_addr = 32'h200; #1;
    chk("r_tie_i_gnt", i_gnt, 1);
    chk("r_tie_d_gnt", d_gnt, 0);
    tick();
    i_req = 0; d_req = 0; respond(32'h3); tick();

    // enable low: no request, no grant
    clr_in();
    en = 0; i_req = 1; d_req = 1; m_gnt = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("e%0d_m_req", k), m_req, 0);
      chk($sformatf("e%0d_gnt", k), i_gnt | d_gnt, 0);
      tick();
    end
    en = 1; clr_in();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch requester (fetch stage) and the data requester (load/store unit). It uses round-robin arbitration with at most one outstanding transaction and routes each response back to its owner. A response timeout guards against a hung memory: on expiry the arbiter returns a safe response (NOOP for fetches) and flags an error. It sits between the core pipeline and the memory/bus interface.

## Interface

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port
- TIMEOUT, 255, cycles to wait for i_M_RVALID after a grant; minimum 1

Ports:
- i_CLK  input  1  core clock; all logic is rising-edge
- i_RST  input  1  reset, asynchronous, active-high
- i_EN  input  1  arbiter enable; when low, no new grant is issued (an outstanding transaction still completes)
- i_I_REQ  input  1  fetch request; held until o_I_GNT
- i_I_ADDR  input  ADDR_W  fetch address
- o_I_GNT  output  1  fetch request accepted by memory this cycle
- o_I_RVALID  output  1  fetch response valid, 1-cycle pulse
- o_I_RDATA  output  32  fetch response data
- i_D_REQ  input  1  data request; held until o_D_GNT
- i_D_WE  input  1  1 = write, 0 = read
- i_D_BE  input  4  byte enables
- i_D_ADDR  input  ADDR_W  data address
- i_D_WDATA  input  32  write data
- o_D_GNT  output  1  data request accepted this cycle
- o_D_RVALID  output  1  data response or write ack, 1-cycle pulse
- o_D_RDATA  output  32  read data (0 for writes)
- o_M_REQ  output  1  memory request
- o_M_WE, o_M_BE, o_M_ADDR, o_M_WDATA  output  1/4/ADDR_W/32  forwarded from the selected requester
- i_M_GNT  input  1  memory accepts the request this cycle
- i_M_RVALID  input  1  memory response, exactly one per accepted request (reads and writes)
- i_M_RDATA  input  32  memory read data
- o_BUS_ERR  output  1  1-cycle pulse on response timeout

## Operation

- States:
  - IDLE
  - WAIT_I: fetch outstanding
  - WAIT_D: data outstanding
- IDLE with i_EN=1:
  - Select a winner among the active requests.
  - Drive o_M_REQ=1 and the winner's fields combinationally.
  - If i_M_GNT=1, pulse the winner's GNT the same cycle, go to WAIT_I or WAIT_D, clear the timeout counter, and record the winner as last-granted.
- Arbitration:
  - A single requester wins unconditionally.
  - If both request, the one not last granted wins.
  - The last-granted pointer resets to D, so after reset the fetch wins the first tie.
  - The pointer updates only on i_M_GNT, not when a request is merely presented.
- Without i_M_GNT:
  - The selection is held stable; it is not re-arbitrated while o_M_REQ is high.
  - The winner is latched in a registered pending-select until granted.
- Non-selected requester's fields are ignored, and its GNT stays 0.
- WAIT_x:
  - o_M_REQ=0.
  - On i_M_RVALID: route i_M_RDATA to the owner's RDATA, pulse the owner's RVALID, return to IDLE.
  - For a data write, o_D_RDATA=0.
- Timeout:
  - In WAIT_x, if the counter reaches TIMEOUT without i_M_RVALID, pulse o_BUS_ERR and the owner's RVALID, then return to IDLE.
  - Fetch timeout returns RDATA=32'h00000013 (NOOP). Data timeout returns RDATA=0.
  - A late i_M_RVALID arriving in IDLE is dropped.
- i_M_RVALID while IDLE is ignored, and no RVALID is produced.
- i_EN=0: IDLE holds, o_M_REQ=0; WAIT_x proceeds normally.

## Timing

- Reset values:
  - state=IDLE, last-granted=D, counter=0.
  - All GNT, RVALID, o_M_REQ and o_BUS_ERR = 0.
  - o_I_RDATA=32'h00000013, o_D_RDATA=0.
- GNT is combinational from i_M_GNT (0-cycle). RVALID and RDATA are combinational from i_M_RVALID in the response cycle.
- Minimum transaction: grant in cycle N, response in cycle N+1, next grant in cycle N+2. There is no grant in the response cycle.
- Timeout fires in the TIMEOUT-th cycle after the grant cycle.
- Reset asserted mid-transaction aborts it immediately, with no RVALID and no error.
- i_M_RVALID in the same cycle the counter hits TIMEOUT: the real response wins and o_BUS_ERR stays 0.

## Structure

- Shared package (core_pkg):
  - NOOP constant 32'h00000013
  - arbiter state encoding (IDLE/WAIT_I/WAIT_D)
- Single module. The timeout counter is inline (width $clog2(TIMEOUT+1)), so no sub-module is needed.

## Test plan

- Fetch only:
  - Stimulus: I_REQ with addr 0x100; memory grants immediately and responds 1 cycle later with 0xDEADBEEF.
  - Required: o_I_GNT in cycle 0, o_I_RVALID in cycle 1 with o_I_RDATA=0xDEADBEEF; o_D_* stay 0.
- Contention:
  - Stimulus: both requests held for 4 transactions after reset.
  - Required: grants in order I, D, I, D; o_M_ADDR matches each winner.
- Stall:
  - Stimulus: i_M_GNT low for 3 cycles while both request.
  - Required: o_M_ADDR stays on the fetch address all 3 cycles; the selection does not flip to D.
- Write:
  - Stimulus: D write with BE=4'b0011, data 0x12345678.
  - Required: o_M_WE=1, o_M_BE=3, o_M_WDATA=0x12345678; ack gives o_D_RVALID with RDATA=0.
- Timeout:
  - Stimulus: TIMEOUT=4, fetch granted, no response.
  - Required: o_BUS_ERR and o_I_RVALID in cycle 4 with RDATA=0x00000013; an RVALID in cycle 6 is ignored.
- Reset and enable:
  - Stimulus: i_RST asserted while in WAIT_D.
  - Required: no RVALID; state returns to IDLE and outputs go to their reset values.
  - Stimulus: i_EN=0 with pending requests.
  - Required: o_M_REQ stays 0.
